// File: rtl/cp0.sv
// rtl/cp0.sv - MIPS coprocessor-0 exception/interrupt controller (optional PRId via CP0_PRID_EN)
module cp0 #(
   parameter logic [31:0] PRID_VALUE = 32'h2022_0707
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  addr,
   input  logic [31:0] din,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] dout,
   output logic [31:0] EPCOut,
   output logic        Req
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;

   // SR fields
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   // EPC
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] pc_word;

   // request is gated by reset so an exception code seen during reset never redirects
   always_comb begin
      int_req = (|(HWInt & im)) & ie & ~exl & reset;
      exc_req = (ExcCodeIn != 5'd0) & ~exl & reset;
      Req     = int_req | exc_req;
      pc_word = {VPC[31:2], 2'b00};
   end

   assign EPCOut = epc;

`ifdef CP0_PRID_EN
   logic unused_bits;
   assign unused_bits = ^VPC[1:0];
`else
   logic unused_bits;
   assign unused_bits = ^{VPC[1:0], PRID_VALUE};
`endif

   // mfc0 read mux
   always_comb begin
      dout = 32'd0;
      case (addr)
         ADDR_SR:    dout = {16'd0, im, 8'd0, exl, ie};
         ADDR_CAUSE: dout = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
         ADDR_EPC:   dout = epc;
`ifdef CP0_PRID_EN
         5'd15:      dout = PRID_VALUE;
`endif
         default:    dout = 32'd0;
      endcase
   end

   // state update: taken request > eret > mtc0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
      end else begin
         ip <= HWInt;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= int_req ? 5'd0 : ExcCodeIn;
            epc      <= BDIn ? (pc_word - 32'd4) : pc_word;
         end else begin
            if (en && addr == ADDR_SR) begin
               im  <= din[15:10];
               ie  <= din[0];
               exl <= din[1] & ~EXLClr;
            end else if (EXLClr) begin
               exl <= 1'b0;
            end
            if (en && addr == ADDR_EPC) begin
               epc <= din;
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0.sv
// tb/tb_cp0.sv - directed self-checking bench for cp0
module tb_cp0;

   logic        clk;
   logic        reset;
   logic        en;
   logic [4:0]  addr;
   logic [31:0] din;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] dout;
   logic [31:0] EPCOut;
   logic        Req;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] PRID = 32'h2022_0707;

   cp0 #(.PRID_VALUE(PRID)) dut (
      .clk(clk), .reset(reset), .en(en), .addr(addr), .din(din),
      .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
      .EXLClr(EXLClr), .dout(dout), .EPCOut(EPCOut), .Req(Req)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, dout, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; BDIn = 1'b0;
   endtask

   initial begin
      logic [31:0] prid_exp;
      reset = 1'b0; en = 1'b0; addr = 5'd0; din = 32'd0; VPC = 32'd0;
      BDIn = 1'b0; ExcCodeIn = 5'd12; HWInt = 6'd0; EXLClr = 1'b0;

      // reset held while clock runs, exception code present
      repeat (3) tick();
      chk("rst_req", {31'd0, Req}, 32'd0);
      chk("rst_epc", EPCOut, 32'd0);
      rd("rst_sr", 5'd12, 32'd0);
      rd("rst_cause", 5'd13, 32'd0);

      // synchronous exception
      reset = 1'b1; ExcCodeIn = 5'd12; VPC = 32'h3010; BDIn = 1'b0;
      #1;
      chk("exc_req", {31'd0, Req}, 32'd1);
      tick();
      idle();
      #1;
      chk("exc_epc", EPCOut, 32'h3010);
      rd("exc_cause", 5'd13, 32'h0000_0030);
      rd("exc_sr", 5'd12, 32'h0000_0002);
      chk("exc_req_drop", {31'd0, Req}, 32'd0);
      ExcCodeIn = 5'd4;
      #1;
      chk("exc_blocked", {31'd0, Req}, 32'd0);
      ExcCodeIn = 5'd0; EXLClr = 1'b1;
      tick();
      idle();
      rd("eret_sr", 5'd12, 32'd0);

      // delay-slot exception
      ExcCodeIn = 5'd4; VPC = 32'h3024; BDIn = 1'b1;
      #1;
      chk("bd_req", {31'd0, Req}, 32'd1);
      tick();
      idle();
      chk("bd_epc", EPCOut, 32'h3020);
      rd("bd_cause", 5'd13, 32'h8000_0010);
      EXLClr = 1'b1;
      tick();
      idle();

      // delay slot at address 2 -> EPC wraps
      ExcCodeIn = 5'd4; VPC = 32'h0000_0002; BDIn = 1'b1;
      tick();
      idle();
      chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);
      EXLClr = 1'b1;
      tick();
      idle();

      // interrupt beats exception code
      en = 1'b1; addr = 5'd12; din = 32'h0000_0401;
      tick();
      idle();
      rd("im_sr", 5'd12, 32'h0000_0401);
      HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h3100;
      #1;
      chk("int_req", {31'd0, Req}, 32'd1);
      tick();
      idle();
      rd("int_cause", 5'd13, 32'h0000_0400);
      chk("int_epc", EPCOut, 32'h3100);
      rd("int_sr", 5'd12, 32'h0000_0403);
      chk("int_masked", {31'd0, Req}, 32'd0);
      HWInt = 6'b100000;
      tick();
      rd("ip_track", 5'd13, 32'h0000_8000);

      // eret with interrupt still pending -> request returns
      HWInt = 6'b000001; EXLClr = 1'b1;
      tick();
      idle();
      rd("eret2_sr", 5'd12, 32'h0000_0401);
      chk("int_reassert", {31'd0, Req}, 32'd1);
      tick();
      // EXL=1 now; eret together with mtc0 SR=0x403
      HWInt = 6'd0; en = 1'b1; addr = 5'd12; din = 32'h0000_0403; EXLClr = 1'b1;
      #1;
      chk("clr_mtc0_noreq", {31'd0, Req}, 32'd0);
      tick();
      idle();
      rd("clr_mtc0_sr", 5'd12, 32'h0000_0401);

      // mtc0 EPC visible next cycle; Cause ignores writes
      en = 1'b1; addr = 5'd14; din = 32'h1234_5678;
      tick();
      idle();
      chk("mtc0_epc", EPCOut, 32'h1234_5678);
      en = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
      tick();
      idle();
      rd("cause_ro", 5'd13, 32'd0);

      // mtc0 discarded when request taken
      en = 1'b1; addr = 5'd14; din = 32'hDEAD_0000; ExcCodeIn = 5'd8; VPC = 32'h4000;
      tick();
      idle();
      chk("req_over_mtc0", EPCOut, 32'h4000);

      // PRId and unmapped register
`ifdef CP0_PRID_EN
      prid_exp = PRID;
`else
      prid_exp = 32'd0;
`endif
      rd("prid", 5'd15, prid_exp);
      rd("unmapped", 5'd7, 32'd0);

      // asynchronous reset mid-handler
      @(negedge clk);
      ExcCodeIn = 5'd3;
      reset = 1'b0;
      #1;
      rd("async_sr", 5'd12, 32'd0);
      chk("async_epc", EPCOut, 32'd0);
      chk("async_req", {31'd0, Req}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
